// File: rtl/mips32_dbg_pkg.sv
// Shared debug-infrastructure definitions for the risc_pipe_mips32 core:
// memory geometry and the dump-reader FSM state encoding.
package mips32_dbg_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    READ,
    CAPTURE,
    SEND
  } dump_state_e;

endpackage

// File: rtl/mem_dump_reader.sv
// Reads a window of the core's data memory after HALTED and streams each word
// with its address over valid/ready. Define DUMP_CHECKSUM_EN to add a running checksum output.
module mem_dump_reader
  import mips32_dbg_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int CNT_W  = 11
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  dump_state_e       state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;

  assign mem_rd_addr = addr;
  assign busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    case (state)
      IDLE:      if (start && (count != '0)) state_next = WAIT_HALT;
      WAIT_HALT: if (halted) state_next = READ;
      READ: begin
        mem_rd_en  = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE:   state_next = SEND;
      SEND:      if (out_ready) state_next = out_last ? IDLE : READ;
      default:   state_next = IDLE;
    endcase
  end

  // The read data arrives one cycle after the strobe, so CAPTURE is where it lands.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              addr      <= base_addr;
              remaining <= count;
            end else begin
              done <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          out_data  <= mem_rd_data;
          out_addr  <= addr;
          out_valid <= 1'b1;
          out_last  <= (remaining == CNT_W'(1));
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              done <= 1'b1;
            end else begin
              addr      <= addr + ADDR_W'(1);
              remaining <= remaining - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // Sum of accepted words; a zero-length start clears it too, so done always reports this dump.
  always_ff @(posedge clk1) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if ((state == SEND) && out_ready) begin
      checksum <= checksum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: directed windows are queued as expected
// beats and a monitor compares every accepted output word against the queue.
module tb_mem_dump_reader;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] count = '0;
  logic        halted = 1'b0;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] mem [1024];
  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_count = 0;
  int          rd_count = 0;
  int          beat_count = 0;

  mem_dump_reader dut (
    .clk1(clk1), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .halted(halted), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
`ifdef DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk1 = ~clk1;

  // Synchronous-read memory model: data valid the cycle after the strobe.
  always @(posedge clk1) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] b, input logic [10:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic pushBeat(input logic [9:0] a, input logic [31:0] d, input logic l);
    beat_t b;
    b.addr = a;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, "_done_seen"}, done, 1);
    checkOutput({name, "_busy_at_done"}, busy, 0);
    tick();
    checkOutput({name, "_done_one_cycle"}, done, 0);
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, "_valid_seen"}, out_valid, 1);
  endtask

  // Monitor: count strobes and done pulses, and compare every accepted beat.
  always @(negedge clk1) begin
    if (done) done_count++;
    if (mem_rd_en) rd_count++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat_addr", {54'd0, out_addr}, 64'hFFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        checkOutput("beat_addr", {54'd0, out_addr}, {54'd0, b.addr});
        checkOutput("beat_data", {32'd0, out_data}, {32'd0, b.data});
        checkOutput("beat_last", {63'd0, out_last}, {63'd0, b.last});
        beat_count++;
      end
    end
  end

  initial begin
    int dc, rc, bc, lat;
    logic [31:0] hold_data;
    logic [9:0]  hold_addr;
    logic        stable;

    foreach (mem[i]) mem[i] = 32'hDEAD_0000 + i;
    mem[120]  = 32'd85;
    mem[121]  = 32'd130;
    mem[1023] = 32'd7;
    mem[0]    = 32'd9;
    mem[500]  = 32'd85;
    mem[501]  = 32'd130;
    mem[502]  = 32'hFFFF_FFFF;

    repeat (3) tick();
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rd_en", mem_rd_en, 0);
    checkOutput("reset_rd_addr", mem_rd_addr, 0);
    checkOutput("reset_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Basic two-word dump with the core already halted.
    halted = 1'b1;
    out_ready = 1'b1;
    dc = done_count;
    bc = beat_count;
    pushBeat(10'd120, 32'd85, 1'b0);
    pushBeat(10'd121, 32'd130, 1'b1);
    applyStimulus(10'd120, 11'd2);
    checkOutput("basic_busy", busy, 1);
    waitDone("basic");
    checkOutput("basic_done_pulses", done_count - dc, 1);
    checkOutput("basic_beats", beat_count - bc, 2);
    checkOutput("basic_busy_after", busy, 0);

    // Reads held off until halted; first valid in the third cycle after halted is raised.
    halted = 1'b0;
    pushBeat(10'd120, 32'd85, 1'b0);
    pushBeat(10'd121, 32'd130, 1'b1);
    applyStimulus(10'd120, 11'd2);
    rc = rd_count;
    repeat (20) tick();
    checkOutput("halt_no_read", rd_count - rc, 0);
    checkOutput("halt_busy_waiting", busy, 1);
    halted = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("halt_latency", lat, 3);
    waitDone("halt");

    // Backpressure on the first beat.
    out_ready = 1'b0;
    pushBeat(10'd120, 32'd85, 1'b0);
    pushBeat(10'd121, 32'd130, 1'b1);
    applyStimulus(10'd120, 11'd2);
    waitValid("bp");
    hold_data = out_data;
    hold_addr = out_addr;
    rc = rd_count;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (!out_valid || out_data !== hold_data || out_addr !== hold_addr) stable = 1'b0;
    end
    checkOutput("bp_stable", stable, 1);
    checkOutput("bp_held_data", hold_data, 85);
    checkOutput("bp_no_extra_read", rd_count - rc, 0);
    out_ready = 1'b1;
    waitDone("bp");

    // Address wrap from the top of memory.
    pushBeat(10'd1023, 32'd7, 1'b0);
    pushBeat(10'd0, 32'd9, 1'b1);
    applyStimulus(10'd1023, 11'd2);
    waitDone("wrap");

    // Zero-length dump.
    bc = beat_count;
    applyStimulus(10'd5, 11'd0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    tick();
    checkOutput("zero_done_pulse", done, 0);
    repeat (5) tick();
    checkOutput("zero_no_beats", beat_count - bc, 0);

    // Start while busy is ignored.
    halted = 1'b0;
    pushBeat(10'd120, 32'd85, 1'b0);
    pushBeat(10'd121, 32'd130, 1'b1);
    applyStimulus(10'd120, 11'd2);
    repeat (2) tick();
    applyStimulus(10'd1023, 11'd2);
    halted = 1'b1;
    waitDone("ignore_start");

    // Reset while a word is pending.
    out_ready = 1'b0;
    dc = done_count;
    applyStimulus(10'd120, 11'd2);
    waitValid("rst_mid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_done", done, 0);
    out_ready = 1'b1;
    repeat (10) tick();
    checkOutput("rst_mid_no_done", done_count - dc, 0);
    checkOutput("rst_mid_idle", busy, 0);

`ifdef DUMP_CHECKSUM_EN
    pushBeat(10'd500, 32'd85, 1'b0);
    pushBeat(10'd501, 32'd130, 1'b0);
    pushBeat(10'd502, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(10'd500, 11'd3);
    begin
      int n = 0;
      while (!done && n < 200) begin
        tick();
        n++;
      end
    end
    checkOutput("checksum_done", done, 1);
    checkOutput("checksum_value", checksum, 32'h0000_00D6);
    tick();
`endif

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
